// File: rtl/wb_cache_pkg.sv
// Shared types for the write-back cache.
//   cache_state_t : controller states (sweep, idle, lookup, bursts, respond, evict path)
//   valid_t       : per-line valid flag
//   bool_t        : generic single-bit flag (dirty, hit, ...)
package cachepkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_FILL,
        ST_RESPOND,
        ST_EVICT_CHECK,
        ST_EVICT_WB,
        ST_EVICT_DONE
    } cache_state_t;

    typedef logic valid_t;
    typedef logic bool_t;

endpackage

// File: rtl/wb_cache_lru.sv
// True-LRU age update for one set (combinational).
//   ages_i    : current age of every way (0 = most recent, WAYS-1 = least recent)
//   hit_way_i : way being touched by a hit or a completed fill
//   ages_o    : ages after touching hit_way_i
//   victim_o  : way whose current age is WAYS-1
module cache_lru #(
    parameter  int WAYS = 4,
    localparam int AW   = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][AW-1:0] ages_i,
    input  logic [AW-1:0]           hit_way_i,
    output logic [WAYS-1:0][AW-1:0] ages_o,
    output logic [AW-1:0]           victim_o
);

    always_comb begin
        ages_o   = ages_i;
        victim_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            // Ways younger than the touched one age by one; the rest keep
            // their age, so the vector stays a permutation of 0..WAYS-1.
            if (ages_i[w] < ages_i[hit_way_i]) begin
                ages_o[w] = ages_i[w] + 1'b1;
            end
            if (ages_i[w] == AW'(WAYS - 1)) begin
                victim_o = AW'(w);
            end
        end
        ages_o[hit_way_i] = '0;
    end

endmodule

// File: rtl/wb_cache.sv
// Set-associative write-back / write-allocate cache with true-LRU replacement,
// a coherence evict port and a word-serial burst port to the next level.
//   clock, reset           : rising-edge clock, async active-low reset
//   req/we/addr/wdata      : core request, held until done
//   rdata/done             : response, done is a one-cycle pulse
//   evict/evict_done       : coherence evict of the line at addr, held until evict_done
//   busy                   : high whenever the controller is not idle
//   mem_req/we/addr/wdata  : registered beat request (writeback when mem_we=1)
//   mem_rdata/mem_ack      : beat accept / fill data return
module wb_cache
    import cachepkg::*;
#(
    parameter int SETS      = 64,
    parameter int WAYS      = 4,
    parameter int LINEWORDS = 4,
    parameter int ADDRW     = 32,
    parameter int DATAW     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [ADDRW-1:0] addr,
    input  logic [DATAW-1:0] wdata,
    output logic [DATAW-1:0] rdata,
    output logic             done,
    input  logic             evict,
    output logic             evict_done,
    output logic             busy,
    output logic             mem_req,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             mem_ack
);

    localparam int BOW  = $clog2(DATAW / 8);
    localparam int WOW  = $clog2(LINEWORDS);
    localparam int IXW  = $clog2(SETS);
    localparam int AW   = $clog2(WAYS);
    localparam int TAGW = ADDRW - BOW - WOW - IXW;

    function automatic logic [ADDRW-1:0] beat_addr(input logic [TAGW-1:0] t,
                                                    input logic [IXW-1:0]  ix,
                                                    input logic [WOW-1:0]  b);
        return ADDRW'({t, ix, b}) << BOW;
    endfunction

    // Storage: no reset, the INIT sweep establishes valid/dirty/age.
    valid_t                  valid_mem [SETS][WAYS];
    bool_t                   dirty_mem [SETS][WAYS];
    logic [TAGW-1:0]         tag_mem   [SETS][WAYS];
    logic [WAYS-1:0][AW-1:0] age_mem   [SETS];
    logic [DATAW-1:0]        data_mem  [SETS][WAYS][LINEWORDS];

    cache_state_t     state_q, state_d;
    logic [IXW-1:0]   set_q, set_d;
    logic [WOW-1:0]   beat_q, beat_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic             we_q, we_d;
    logic [DATAW-1:0] wdata_q, wdata_d;
    logic [AW-1:0]    way_q, way_d;
    logic [DATAW-1:0] rdata_q, rdata_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
    logic [DATAW-1:0] mem_wdata_q, mem_wdata_d;

    logic [TAGW-1:0] tag_r;
    logic [IXW-1:0]  idx_r;
    logic [WOW-1:0]  off_r, beat_nx;
    bool_t           last_beat;

    assign tag_r     = addr_q[ADDRW-1 -: TAGW];
    assign idx_r     = addr_q[BOW+WOW +: IXW];
    assign off_r     = addr_q[BOW +: WOW];
    assign beat_nx   = beat_q + 1'b1;
    assign last_beat = (beat_q == WOW'(LINEWORDS - 1));

    bool_t                   hit, inv_found;
    logic [AW-1:0]           hit_way, inv_way, lru_victim, victim, lru_way;
    logic [WAYS-1:0][AW-1:0] ages_upd;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[idx_r][w] && tag_mem[idx_r][w] == tag_r) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (!valid_mem[idx_r][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = AW'(w);
            end
        end
    end

    // An empty way is always preferred over displacing a live line.
    assign victim  = inv_found ? inv_way : lru_victim;
    assign lru_way = (state_q == ST_FILL) ? way_q : hit_way;

    cache_lru #(.WAYS(WAYS)) u_lru (
        .ages_i   (age_mem[idx_r]),
        .hit_way_i(lru_way),
        .ages_o   (ages_upd),
        .victim_o (lru_victim)
    );

    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        way_d       = way_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_INIT: begin
                set_d = set_q + 1'b1;
                if (set_q == IXW'(SETS - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (evict || req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    state_d = evict ? ST_EVICT_CHECK : ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    rdata_d = we_q ? wdata_q : data_mem[idx_r][hit_way][off_r];
                    state_d = ST_RESPOND;
                end else begin
                    way_d     = victim;
                    beat_d    = '0;
                    mem_req_d = 1'b1;
                    if (valid_mem[idx_r][victim] && dirty_mem[idx_r][victim]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = beat_addr(tag_mem[idx_r][victim], idx_r, '0);
                        mem_wdata_d = data_mem[idx_r][victim][0];
                        state_d     = ST_WRITEBACK;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = beat_addr(tag_r, idx_r, '0);
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_WRITEBACK, ST_EVICT_WB: begin
                if (mem_ack) begin
                    beat_d = beat_nx;
                    if (!last_beat) begin
                        mem_addr_d  = beat_addr(tag_mem[idx_r][way_q], idx_r, beat_nx);
                        mem_wdata_d = data_mem[idx_r][way_q][beat_nx];
                    end else if (state_q == ST_WRITEBACK) begin
                        // Chain straight into the refill burst; mem_req stays up.
                        mem_we_d   = 1'b0;
                        mem_addr_d = beat_addr(tag_r, idx_r, '0);
                        state_d    = ST_FILL;
                    end else begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        state_d   = ST_EVICT_DONE;
                    end
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    beat_d = beat_nx;
                    if (beat_q == off_r) rdata_d = we_q ? wdata_q : mem_rdata;
                    if (last_beat) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_RESPOND;
                    end else begin
                        mem_addr_d = beat_addr(tag_r, idx_r, beat_nx);
                    end
                end
            end
            ST_RESPOND:    state_d = ST_IDLE;
            ST_EVICT_CHECK: begin
                if (hit && dirty_mem[idx_r][hit_way]) begin
                    way_d       = hit_way;
                    beat_d      = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = beat_addr(tag_r, idx_r, '0);
                    mem_wdata_d = data_mem[idx_r][hit_way][0];
                    state_d     = ST_EVICT_WB;
                end else begin
                    state_d = ST_EVICT_DONE;
                end
            end
            ST_EVICT_DONE: state_d = ST_IDLE;
            default:       state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            set_q       <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            way_q       <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            set_q       <= set_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            way_q       <= way_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Array updates. Reset forces ST_INIT asynchronously, so an aborted fill
    // stops writing at once and its partial line is never marked valid.
    always_ff @(posedge clock) begin
        case (state_q)
            ST_INIT: begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_mem[set_q][w] <= 1'b0;
                    dirty_mem[set_q][w] <= 1'b0;
                    age_mem[set_q][w]   <= AW'(w);
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    if (we_q) begin
                        data_mem[idx_r][hit_way][off_r] <= wdata_q;
                        dirty_mem[idx_r][hit_way]       <= 1'b1;
                    end
                    age_mem[idx_r] <= ages_upd;
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    // Write data is merged as its beat arrives.
                    data_mem[idx_r][way_q][beat_q] <= (we_q && beat_q == off_r) ? wdata_q : mem_rdata;
                    if (last_beat) begin
                        valid_mem[idx_r][way_q] <= 1'b1;
                        dirty_mem[idx_r][way_q] <= we_q;
                        tag_mem[idx_r][way_q]   <= tag_r;
                        age_mem[idx_r]          <= ages_upd;
                    end
                end
            end
            ST_EVICT_CHECK: begin
                if (hit && !dirty_mem[idx_r][hit_way]) valid_mem[idx_r][hit_way] <= 1'b0;
            end
            ST_EVICT_WB: begin
                if (mem_ack && last_beat) begin
                    valid_mem[idx_r][way_q] <= 1'b0;
                    dirty_mem[idx_r][way_q] <= 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign rdata      = rdata_q;
    assign done       = (state_q == ST_RESPOND);
    assign evict_done = (state_q == ST_EVICT_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_wb_cache.sv
// Bench for wb_cache: directed scenarios followed by random traffic, checked
// against an architectural memory image plus a recency-list cache model.
module tb_wb_cache;

    localparam int SETS = 64;
    localparam int WAYS = 4;
    localparam int LW   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, we = 1'b0, evict = 1'b0, mem_ack = 1'b0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        done, evict_done, busy, mem_req, mem_we;

    wb_cache #(.SETS(SETS), .WAYS(WAYS), .LINEWORDS(LW), .ADDRW(32), .DATAW(32)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .evict(evict), .evict_done(evict_done), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Backing store (next level) and architectural image (what a read must return).
    logic [31:0] backing [logic [31:0]];
    logic [31:0] golden  [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h0100_0193) ^ 32'hC0FF_EE00;
    endfunction
    function automatic logic [31:0] rd_back(input logic [31:0] a);
        return backing.exists(a) ? backing[a] : dflt(a);
    endfunction
    function automatic logic [31:0] rd_gold(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : dflt(a);
    endfunction

    // Next-level responder: records every accepted beat as {we, addr}.
    bit          rand_wait = 1'b0;
    logic [32:0] beats[$];
    logic [32:0] xbeats[$];

    always @(negedge clock) begin
        mem_ack = 1'b0;
        if (mem_req && reset && (!rand_wait || $urandom_range(0, 2) != 0)) begin
            mem_ack = 1'b1;
            beats.push_back({mem_we, mem_addr});
            if (mem_we) backing[mem_addr] = mem_wdata;
            mem_rdata = rd_back(mem_addr);
        end
    end

    // Cache model: per set, ways listed from most to least recently used.
    bit          mv [SETS][WAYS];
    bit          md [SETS][WAYS];
    logic [31:0] mt [SETS][WAYS];
    int          ord[SETS][WAYS];

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w] = 0; md[s][w] = 0; ord[s][w] = w;
            end
    endfunction

    function automatic void touch(input int s, input int h);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (ord[s][i] == h) p = i;
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = h;
    endfunction

    function automatic int find_way(input int s, input logic [31:0] t);
        for (int w = 0; w < WAYS; w++) if (mv[s][w] && mt[s][w] == t) return w;
        return -1;
    endfunction

    function automatic void push_line(input bit w, input logic [31:0] base);
        for (int b = 0; b < LW; b++) xbeats.push_back({w, base + 32'(4 * b)});
    endfunction

    function automatic void model_access(input logic [31:0] a, input bit w, input logic [31:0] wd);
        int s = int'((a >> 4) % SETS);
        logic [31:0] t = a >> 10;
        int h = find_way(s, t);
        if (h < 0) begin
            for (int i = WAYS - 1; i >= 0; i--) if (!mv[s][i]) h = i;
            if (h < 0) h = ord[s][WAYS-1];
            if (mv[s][h] && md[s][h]) push_line(1'b1, (mt[s][h] << 10) | 32'(s << 4));
            push_line(1'b0, a & ~32'hF);
            mv[s][h] = 1; mt[s][h] = t; md[s][h] = 0;
        end
        if (w) begin
            md[s][h] = 1;
            golden[a & ~32'h3] = wd;
        end
        touch(s, h);
    endfunction

    function automatic void model_evict(input logic [31:0] a);
        int s = int'((a >> 4) % SETS);
        int h = find_way(s, a >> 10);
        if (h >= 0) begin
            if (md[s][h]) push_line(1'b1, a & ~32'hF);
            mv[s][h] = 0; md[s][h] = 0;
        end
    endfunction

    task automatic step();
        @(negedge clock); #1;
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_nbeats"}, 64'(beats.size()), 64'(xbeats.size()));
        for (int i = 0; i < beats.size() && i < xbeats.size(); i++)
            chk({tag, "_beat"}, 64'(beats[i]), 64'(xbeats[i]));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 500) begin step(); lat++; end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic wait_evict_done(output int lat);
        lat = 0;
        while (!evict_done && lat < 500) begin step(); lat++; end
        chk("evict_done_seen", 64'(evict_done), 64'd1);
    endtask

    task automatic finish_access(input string tag, input int lat, input logic [31:0] exp_rd);
        chk({tag, "_rdata"}, 64'(rdata), 64'(exp_rd));
        check_beats(tag);
        if (!rand_wait) chk({tag, "_lat"}, 64'(lat), 64'(2 + xbeats.size()));
        req = 1'b0; we = 1'b0;
        step();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic do_access(input string tag, input logic [31:0] a, input bit w, input logic [31:0] wd);
        int lat;
        logic [31:0] exp_rd;
        xbeats.delete(); beats.delete();
        model_access(a, w, wd);
        exp_rd = rd_gold(a & ~32'h3);
        addr = a; we = w; wdata = wd; req = 1'b1;
        wait_done(lat);
        finish_access(tag, lat, exp_rd);
    endtask

    task automatic do_evict(input string tag, input logic [31:0] a);
        int lat;
        xbeats.delete(); beats.delete();
        model_evict(a);
        addr = a; evict = 1'b1;
        wait_evict_done(lat);
        check_beats(tag);
        if (!rand_wait)
            chk({tag, "_lat"}, 64'(lat >= 2 + xbeats.size() && lat <= 3 + xbeats.size()), 64'd1);
        evict = 1'b0;
        step();
        chk({tag, "_evict_pulse"}, 64'(evict_done), 64'd0);
    endtask

    task automatic release_and_count(input string tag);
        int cnt = 0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        while (busy && cnt < 1000) begin cnt++; step(); end
        chk({tag, "_init_cycles"}, 64'(cnt), 64'(SETS));
        model_reset();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] exp_rd, ra;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_evict_done", 64'(evict_done), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        release_and_count("boot");

        // Cold miss, write hit, read hit.
        do_access("cold_rd", 32'h0000_0100, 1'b0, '0);
        do_access("wr_hit", 32'h0000_0104, 1'b1, 32'hDEAD_BEEF);
        do_access("rd_hit", 32'h0000_0104, 1'b0, '0);

        // Evict of an absent line.
        do_evict("ev_absent", 32'h0000_3300);

        // Five tags into set 0: two dirty, then LRU eviction with writebacks.
        do_access("s0_t1", 32'h0000_0400, 1'b1, 32'h1111_0001);
        do_access("s0_t2", 32'h0000_0804, 1'b1, 32'h2222_0002);
        do_access("s0_t3", 32'h0000_0C08, 1'b0, '0);
        do_access("s0_t4", 32'h0000_100C, 1'b0, '0);
        do_access("s0_t5", 32'h0000_1400, 1'b0, '0);
        do_access("s0_t1_back", 32'h0000_0400, 1'b0, '0);

        // Evict and request together: evict goes first.
        xbeats.delete(); beats.delete();
        model_evict(32'h0000_0100);
        addr = 32'h0000_0100; we = 1'b0; evict = 1'b1; req = 1'b1;
        wait_evict_done(lat);
        check_beats("evreq_ev");
        evict = 1'b0;
        xbeats.delete(); beats.delete();
        model_access(32'h0000_0100, 1'b0, '0);
        exp_rd = rd_gold(32'h0000_0100);
        wait_done(lat);
        chk("evreq_rdata", 64'(rdata), 64'(exp_rd));
        check_beats("evreq_rd");
        req = 1'b0;
        step();

        // Reset during the second fill beat.
        beats.delete();
        addr = 32'h0000_2050; we = 1'b0; req = 1'b1;
        lat = 0;
        while (beats.size() < 1 && lat < 500) begin step(); lat++; end
        chk("rst_first_beat", 64'(beats.size()), 64'd1);
        @(posedge clock); #1;
        chk("rst_beat2_req", 64'(mem_req), 64'd1);
        chk("rst_beat2_addr", 64'(mem_addr), 64'h2054);
        reset = 1'b0;
        #1;
        chk("rst_async_mem_req", 64'(mem_req), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd1);
        req = 1'b0;
        repeat (2) @(negedge clock);
        release_and_count("mid_rst");
        golden = backing;
        do_access("post_rst_rd", 32'h0000_2050, 1'b0, '0);

        // Random traffic over a few contended sets with random ack delays.
        rand_wait = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] sets4 [4];
            sets4[0] = 0; sets4[1] = 1; sets4[2] = 16; sets4[3] = 63;
            ra = (32'($urandom_range(0, 7)) << 10) | (sets4[$urandom_range(0, 3)] << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 15) do_evict("rnd_ev", ra);
            else do_access("rnd_acc", ra, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
